// File: rtl/vec_alu_pkg.sv
// Shared types for the vector ALU engine: lane operations, controller states
// and the lane-count helper used to size the datapath.
package vec_alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    SADD = 2'd2,
    MAX  = 2'd3
  } alu_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_A_REQ,
    RD_A_DATA,
    RD_B_REQ,
    RD_B_DATA,
    WR_REQ,
    WR_DATA,
    DONE
  } state_t;

  function automatic int lanes(input int dataBits, input int elemBits);
    return dataBits / elemBits;
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One unsigned element lane of the vector ALU; purely combinational.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int ELEM_BITS = 8
) (
  input  logic [ELEM_BITS-1:0] a,
  input  logic [ELEM_BITS-1:0] b,
  input  alu_mode_t            mode,
  output logic [ELEM_BITS-1:0] y
);

  logic [ELEM_BITS:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // The extra sum bit is the carry that saturating add clamps on.
  always_comb begin
    y = sum[ELEM_BITS-1:0];
    case (mode)
      ADD:  y = sum[ELEM_BITS-1:0];
      SUB:  y = a - b;
      SADD: y = sum[ELEM_BITS] ? {ELEM_BITS{1'b1}} : sum[ELEM_BITS-1:0];
      MAX:  y = (a > b) ? a : b;
      default: y = sum[ELEM_BITS-1:0];
    endcase
  end

endmodule

// File: rtl/vec_alu_compute.sv
// Burst-streaming vector ALU: reads A and B into a beat buffer, combines them
// lane-wise in place, writes the buffer back as C and reports the cycle count.
module vec_alu_compute
  import vec_alu_pkg::*;
#(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 32,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32,
  parameter int ELEM_BITS      = 8,
  parameter int MAX_BURST      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  input  logic [1:0]                mode,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [HOST_DATA_BITS-1:0] a_addr,
  input  logic [HOST_DATA_BITS-1:0] b_addr,
  input  logic [HOST_DATA_BITS-1:0] c_addr,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  output logic                      mem_req_valid,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic                      mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  input  logic                      mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_rd_ready
);

  localparam int LANES      = lanes(MEM_DATA_BITS, ELEM_BITS);
  localparam int BEAT_BYTES = MEM_DATA_BITS / 8;
  localparam int IDX_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CNT_W      = IDX_W + 1;

  state_t                    state_q;
  alu_mode_t                 mode_q;
  logic [HOST_DATA_BITS-1:0] rem_q;
  logic [MEM_ADDR_BITS-1:0]  aPtr_q, bPtr_q, cPtr_q;
  logic [CNT_W-1:0]          burst_q;
  logic [CNT_W-1:0]          idx_q;
  logic [HOST_DATA_BITS-1:0] cycles_q;
  logic                      launchPrev_q;
  logic                      reqValid_q, reqOpcode_q;
  logic [MEM_LEN_BITS-1:0]   reqLen_q;
  logic [MEM_ADDR_BITS-1:0]  reqAddr_q;
  logic                      wrValid_q, rdReady_q, finish_q, ecValid_q;
  logic [MEM_DATA_BITS-1:0]  wrBits_q;
  logic [MEM_DATA_BITS-1:0]  opBuf_q [2**IDX_W];

  logic                      launchRise, beatFire, lastBeat;
  logic [IDX_W-1:0]          bufIdx;
  logic [MEM_DATA_BITS-1:0]  bufRd, aluY;
  logic [MEM_ADDR_BITS-1:0]  step;
  logic [HOST_DATA_BITS-1:0] remAfter;
  logic [CNT_W-1:0]          firstBurst, nextBurst;

  function automatic logic [CNT_W-1:0] burstFor(input logic [HOST_DATA_BITS-1:0] r);
    return (r >= HOST_DATA_BITS'(MAX_BURST)) ? CNT_W'(MAX_BURST) : CNT_W'(r);
  endfunction

  assign launchRise = launch & ~launchPrev_q;
  assign beatFire   = mem_rd_valid & rdReady_q;
  assign lastBeat   = (idx_q == burst_q - CNT_W'(1));
  assign bufIdx     = idx_q[IDX_W-1:0];
  assign bufRd      = opBuf_q[bufIdx];
  assign step       = MEM_ADDR_BITS'(burst_q) * MEM_ADDR_BITS'(BEAT_BYTES);
  assign remAfter   = rem_q - HOST_DATA_BITS'(burst_q);
  assign firstBurst = burstFor(length);
  assign nextBurst  = burstFor(remAfter);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_alu_lane #(.ELEM_BITS(ELEM_BITS)) u_lane (
      .a    (bufRd[l*ELEM_BITS +: ELEM_BITS]),
      .b    (mem_rd_bits[l*ELEM_BITS +: ELEM_BITS]),
      .mode (mode_q),
      .y    (aluY[l*ELEM_BITS +: ELEM_BITS])
    );
  end

  // The B pass overwrites each A beat with its result, so one buffer suffices.
  always_ff @(posedge clock) begin
    if (beatFire) begin
      opBuf_q[bufIdx] <= (state_q == RD_B_DATA) ? aluY : mem_rd_bits;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= ADD;
      rem_q        <= '0;
      aPtr_q       <= '0;
      bPtr_q       <= '0;
      cPtr_q       <= '0;
      burst_q      <= '0;
      idx_q        <= '0;
      cycles_q     <= '0;
      launchPrev_q <= 1'b0;
      reqValid_q   <= 1'b0;
      reqOpcode_q  <= 1'b0;
      reqLen_q     <= '0;
      reqAddr_q    <= '0;
      wrValid_q    <= 1'b0;
      wrBits_q     <= '0;
      rdReady_q    <= 1'b0;
      finish_q     <= 1'b0;
      ecValid_q    <= 1'b0;
    end else begin
      launchPrev_q <= launch;
      reqValid_q   <= 1'b0;
      finish_q     <= 1'b0;
      ecValid_q    <= 1'b0;
      // The counter always counts the cycle being entered, so it is seeded with 1.
      if (state_q != IDLE && state_q != DONE && cycles_q != '1) begin
        cycles_q <= cycles_q + HOST_DATA_BITS'(1);
      end
      case (state_q)
        IDLE: begin
          if (launchRise) begin
            mode_q   <= alu_mode_t'(mode);
            rem_q    <= length;
            aPtr_q   <= MEM_ADDR_BITS'(a_addr);
            bPtr_q   <= MEM_ADDR_BITS'(b_addr);
            cPtr_q   <= MEM_ADDR_BITS'(c_addr);
            cycles_q <= HOST_DATA_BITS'(1);
            if (length == '0) begin
              state_q   <= DONE;
              finish_q  <= 1'b1;
              ecValid_q <= 1'b1;
            end else begin
              state_q     <= RD_A_REQ;
              burst_q     <= firstBurst;
              reqValid_q  <= 1'b1;
              reqOpcode_q <= 1'b0;
              reqLen_q    <= MEM_LEN_BITS'(firstBurst - CNT_W'(1));
              reqAddr_q   <= MEM_ADDR_BITS'(a_addr);
            end
          end
        end
        RD_A_REQ, RD_B_REQ: begin
          state_q   <= (state_q == RD_A_REQ) ? RD_A_DATA : RD_B_DATA;
          rdReady_q <= 1'b1;
          idx_q     <= '0;
        end
        RD_A_DATA: begin
          if (beatFire) begin
            idx_q <= idx_q + CNT_W'(1);
            if (lastBeat) begin
              state_q     <= RD_B_REQ;
              rdReady_q   <= 1'b0;
              reqValid_q  <= 1'b1;
              reqOpcode_q <= 1'b0;
              reqAddr_q   <= bPtr_q;
            end
          end
        end
        RD_B_DATA: begin
          if (beatFire) begin
            idx_q <= idx_q + CNT_W'(1);
            if (lastBeat) begin
              state_q     <= WR_REQ;
              rdReady_q   <= 1'b0;
              reqValid_q  <= 1'b1;
              reqOpcode_q <= 1'b1;
              reqAddr_q   <= cPtr_q;
              idx_q       <= '0;
            end
          end
        end
        WR_REQ: begin
          state_q   <= WR_DATA;
          wrValid_q <= 1'b1;
          wrBits_q  <= bufRd;
          idx_q     <= CNT_W'(1);
        end
        WR_DATA: begin
          // idx_q runs one ahead of the beat currently on mem_wr_bits.
          if (idx_q == burst_q) begin
            wrValid_q <= 1'b0;
            aPtr_q    <= aPtr_q + step;
            bPtr_q    <= bPtr_q + step;
            cPtr_q    <= cPtr_q + step;
            rem_q     <= remAfter;
            if (remAfter != '0) begin
              state_q     <= RD_A_REQ;
              burst_q     <= nextBurst;
              reqValid_q  <= 1'b1;
              reqOpcode_q <= 1'b0;
              reqLen_q    <= MEM_LEN_BITS'(nextBurst - CNT_W'(1));
              reqAddr_q   <= aPtr_q + step;
            end else begin
              state_q   <= DONE;
              finish_q  <= 1'b1;
              ecValid_q <= 1'b1;
            end
          end else begin
            wrBits_q <= bufRd;
            idx_q    <= idx_q + CNT_W'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign finish              = finish_q;
  assign event_counter_valid = ecValid_q;
  assign event_counter_value = cycles_q;
  assign mem_req_valid       = reqValid_q;
  assign mem_req_opcode      = reqOpcode_q;
  assign mem_req_len         = reqLen_q;
  assign mem_req_addr        = reqAddr_q;
  assign mem_wr_valid        = wrValid_q;
  assign mem_wr_bits         = wrBits_q;
  assign mem_rd_ready        = rdReady_q;

endmodule

// File: tb/tb_vec_alu_compute.sv
// Directed bench for vec_alu_compute with a beat-addressed memory responder
// and a per-lane reference model for the expected C vectors.
module tb_vec_alu_compute;
  import vec_alu_pkg::*;

  localparam logic [31:0] A_BASE = 32'h0000_1000;
  localparam logic [31:0] B_BASE = 32'h0000_2000;
  localparam logic [31:0] C_BASE = 32'h0000_3000;
  localparam int A_IDX = 512;
  localparam int B_IDX = 1024;
  localparam int C_IDX = 1536;

  logic        clock = 1'b0;
  logic        reset, launch;
  logic [1:0]  mode;
  logic [31:0] length, a_addr, b_addr, c_addr;
  logic        finish, event_counter_valid;
  logic [31:0] event_counter_value;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_ready;

  logic [63:0] mem [2048];
  int          rdPending, rdIdx, wrLeft, wrIdx;
  bit          gaps;
  int          gapErr, strayErr, evErr, finishCount, reqCount;
  logic [31:0] lastCounter;
  int          reqLenQ[$];
  logic [31:0] reqAddrQ[$];
  bit          reqOpQ[$];
  int          assertCount, failCount;

  vec_alu_compute dut (
    .clock               (clock),
    .reset               (reset),
    .launch              (launch),
    .mode                (mode),
    .length              (length),
    .a_addr              (a_addr),
    .b_addr              (b_addr),
    .c_addr              (c_addr),
    .finish              (finish),
    .event_counter_valid (event_counter_valid),
    .event_counter_value (event_counter_value),
    .mem_req_valid       (mem_req_valid),
    .mem_req_opcode      (mem_req_opcode),
    .mem_req_len         (mem_req_len),
    .mem_req_addr        (mem_req_addr),
    .mem_wr_valid        (mem_wr_valid),
    .mem_wr_bits         (mem_wr_bits),
    .mem_rd_valid        (mem_rd_valid),
    .mem_rd_bits         (mem_rd_bits),
    .mem_rd_ready        (mem_rd_ready)
  );

  initial forever #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] refBeat(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [7:0]  x, y;
    logic [8:0]  s;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      x = a[8*j +: 8];
      y = b[8*j +: 8];
      s = {1'b0, x} + {1'b0, y};
      case (m)
        2'd0:    r[8*j +: 8] = s[7:0];
        2'd1:    r[8*j +: 8] = x - y;
        2'd2:    r[8*j +: 8] = s[8] ? 8'hFF : s[7:0];
        default: r[8*j +: 8] = (x > y) ? x : y;
      endcase
    end
    return r;
  endfunction

  // Memory responder: snapshots the DUT at the falling edge, reacts just after the rising edge.
  initial begin
    logic        accNow, reqNow, reqOp, wrNow, finNow, evNow;
    logic [7:0]  reqLen;
    logic [31:0] reqAddr, evVal;
    logic [63:0] wrData;
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    forever begin
      @(negedge clock);
      accNow  = mem_rd_valid && mem_rd_ready;
      reqNow  = mem_req_valid;
      reqOp   = mem_req_opcode;
      reqLen  = mem_req_len;
      reqAddr = mem_req_addr;
      wrNow   = mem_wr_valid;
      wrData  = mem_wr_bits;
      finNow  = finish;
      evNow   = event_counter_valid;
      evVal   = event_counter_value;
      if (reset) begin
        if (finNow) begin
          finishCount++;
          lastCounter = evVal;
        end
        if (evNow != finNow) evErr++;
        if (reqNow) begin
          reqCount++;
          reqLenQ.push_back(int'(reqLen));
          reqAddrQ.push_back(reqAddr);
          reqOpQ.push_back(reqOp);
        end
      end
      @(posedge clock);
      #1;
      if (!reset) begin
        rdPending    = 0;
        wrLeft       = 0;
        mem_rd_valid = 1'b0;
      end else begin
        if (accNow && rdPending > 0) begin
          rdPending--;
          rdIdx++;
        end
        if (wrLeft > 0) begin
          if (wrNow) begin
            mem[wrIdx % 2048] = wrData;
            wrIdx++;
            wrLeft--;
          end else gapErr++;
        end else if (wrNow) strayErr++;
        if (reqNow) begin
          if (reqOp) begin
            wrLeft = int'(reqLen) + 1;
            wrIdx  = int'(reqAddr[13:3]);
          end else begin
            rdPending = int'(reqLen) + 1;
            rdIdx     = int'(reqAddr[13:3]);
          end
        end
        if (rdPending > 0 && (!gaps || $urandom_range(0, 9) >= 3)) begin
          mem_rd_valid = 1'b1;
          mem_rd_bits  = mem[rdIdx % 2048];
        end else begin
          mem_rd_valid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input int len, input bit holdLaunch);
    @(posedge clock);
    #1;
    mode   = m;
    length = len;
    a_addr = A_BASE;
    b_addr = B_BASE;
    c_addr = C_BASE;
    launch = 1'b1;
    if (!holdLaunch) begin
      @(posedge clock);
      #1;
      launch = 1'b0;
    end
  endtask

  task automatic waitFinish(input int target, input string tag);
    int n;
    n = 0;
    while (finishCount < target && n < 3000) begin
      @(posedge clock);
      n++;
    end
    checkOutput(tag, finishCount, target);
  endtask

  // Clears C, runs one vector and checks every C beat against the reference model.
  task automatic runVector(input logic [1:0] m, input int len, input string tag, input int expCounter);
    int start;
    for (int i = 0; i < 64; i++) mem[C_IDX + i] = '0;
    reqLenQ.delete();
    reqAddrQ.delete();
    reqOpQ.delete();
    start = finishCount;
    applyStimulus(m, len, 1'b0);
    waitFinish(start + 1, {tag, "_finish"});
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s_c%0d", tag, i), mem[C_IDX + i], refBeat(m, mem[A_IDX + i], mem[B_IDX + i]));
    end
    if (expCounter >= 0) checkOutput({tag, "_counter"}, lastCounter, expCounter);
    repeat (5) @(posedge clock);
    checkOutput({tag, "_single_finish"}, finishCount, start + 1);
  endtask

  initial begin
    int r0, start, n;
    assertCount = 0; failCount = 0; gapErr = 0; strayErr = 0; evErr = 0;
    finishCount = 0; reqCount = 0; lastCounter = '0; gaps = 1'b0;
    reset = 1'b0; launch = 1'b0; mode = '0; length = '0;
    a_addr = '0; b_addr = '0; c_addr = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_finish", finish, 0);
    checkOutput("rst_req_valid", mem_req_valid, 0);
    checkOutput("rst_rd_ready", mem_rd_ready, 0);
    checkOutput("rst_wr_valid", mem_wr_valid, 0);
    checkOutput("rst_counter", event_counter_value, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    $display("[TB] length=4 add");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) mem[A_IDX + i][8*j +: 8] = 8'(8*i + j + 1);
      mem[B_IDX + i] = {8{8'h01}};
    end
    runVector(ADD, 4, "t1", 16);
    checkOutput("t1_beat0", mem[C_IDX], 64'h0908070605040302);
    checkOutput("t1_beat3", mem[C_IDX + 3], 64'h21201f1e1d1c1b1a);
    checkOutput("t1_req_count", reqLenQ.size(), 3);
    checkOutput("t1_req_len", reqLenQ[0], 3);
    checkOutput("t1_b_addr", reqAddrQ[1], B_BASE);
    checkOutput("t1_wr_opcode", reqOpQ[2], 1);

    $display("[TB] saturating add and wrapping sub");
    for (int i = 0; i < 2; i++) begin
      mem[A_IDX + i] = {8{8'hF0}};
      mem[B_IDX + i] = {8{8'h20}};
    end
    runVector(SADD, 2, "t2", 10);
    checkOutput("t2_sat", mem[C_IDX + 1], 64'hFFFF_FFFF_FFFF_FFFF);
    mem[A_IDX] = '0;
    mem[B_IDX] = {8{8'h01}};
    runVector(SUB, 1, "t3", 7);
    checkOutput("t3_wrap", mem[C_IDX], 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] length=37 max over three bursts");
    for (int i = 0; i < 37; i++) begin
      mem[A_IDX + i] = {$urandom, $urandom};
      mem[B_IDX + i] = {$urandom, $urandom};
    end
    mem[A_IDX] = 64'h00FF_7F80_0102_1000;
    mem[B_IDX] = 64'h0100_8080_0201_0F01;
    runVector(MAX, 37, "t4", 121);
    checkOutput("t4_max_beat0", mem[C_IDX], 64'h01FF_8080_0202_1001);
    checkOutput("t4_req_count", reqLenQ.size(), 9);
    checkOutput("t4_len_b0", reqLenQ[0], 15);
    checkOutput("t4_len_b1", reqLenQ[3], 15);
    checkOutput("t4_len_b2", reqLenQ[6], 4);
    checkOutput("t4_wlen_b2", reqLenQ[8], 4);
    checkOutput("t4_a_addr_b1", reqAddrQ[3], A_BASE + 32'd128);
    checkOutput("t4_a_addr_b2", reqAddrQ[6], A_BASE + 32'd256);
    checkOutput("t4_b_addr_b2", reqAddrQ[7], B_BASE + 32'd256);
    checkOutput("t4_c_addr_b2", reqAddrQ[8], C_BASE + 32'd256);

    $display("[TB] length=20 add with read gaps");
    for (int i = 0; i < 20; i++) begin
      mem[A_IDX + i] = {$urandom, $urandom};
      mem[B_IDX + i] = {$urandom, $urandom};
    end
    mem[A_IDX] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[B_IDX] = {8{8'h01}};
    gaps = 1'b1;
    runVector(ADD, 20, "t5", -1);
    gaps = 1'b0;
    checkOutput("t5_wrap_beat0", mem[C_IDX], 64'h0);

    $display("[TB] length=0 with launch held");
    start = finishCount;
    r0 = reqCount;
    applyStimulus(ADD, 0, 1'b1);
    waitFinish(start + 1, "t6_finish");
    repeat (10) @(posedge clock);
    checkOutput("t6_no_relaunch", finishCount, start + 1);
    checkOutput("t6_no_requests", reqCount, r0);
    checkOutput("t6_counter", lastCounter, 1);
    #1;
    launch = 1'b0;

    $display("[TB] reset during B read");
    for (int i = 0; i < 8; i++) begin
      mem[A_IDX + i] = {$urandom, $urandom};
      mem[B_IDX + i] = {$urandom, $urandom};
    end
    start = finishCount;
    r0 = reqCount;
    applyStimulus(ADD, 8, 1'b0);
    n = 0;
    while (reqCount < r0 + 2 && n < 200) begin
      @(posedge clock);
      n++;
    end
    checkOutput("t7_b_request_seen", reqCount - r0, 2);
    @(negedge clock);
    checkOutput("t7_in_b_data", mem_rd_ready, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t7_rd_ready", mem_rd_ready, 0);
    checkOutput("t7_req_valid", mem_req_valid, 0);
    checkOutput("t7_wr_valid", mem_wr_valid, 0);
    checkOutput("t7_finish", finish, 0);
    checkOutput("t7_counter", event_counter_value, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    checkOutput("t7_no_finish", finishCount, start);
    for (int i = 0; i < 3; i++) begin
      mem[A_IDX + i] = {$urandom, $urandom};
      mem[B_IDX + i] = {$urandom, $urandom};
    end
    runVector(ADD, 3, "t8", 13);

    checkOutput("write_gaps", gapErr, 0);
    checkOutput("stray_writes", strayErr, 0);
    checkOutput("event_valid_vs_finish", evErr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vec_alu_compute.md
# vec_alu_compute

Parametrised multi-lane vector ALU engine, successor to the single-operation add compute block. It sits beside RegFile behind the host/memory DPI pair. On launch it streams vectors A and B from memory in bursts and applies a per-lane operation (add, sub, saturating add, max) to packed elements. It writes result C back and reports a cycle count to the register file.

## Interface
- MEM_LEN_BITS, 8: width of the burst-length field.
- MEM_ADDR_BITS, 32: memory byte-address width.
- MEM_DATA_BITS, 64: memory beat width; must be a multiple of ELEM_BITS.
- HOST_DATA_BITS, 32: width of the register-file values.
- ELEM_BITS, 8: element width. LANES = MEM_DATA_BITS/ELEM_BITS.
- MAX_BURST, 16: beats per burst, a power of two, ≤ 2^MEM_LEN_BITS. Also the operand buffer depth.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- launch  in  1  start request; rising edge sampled in IDLE.
- mode  in  2  0 add-wrap, 1 sub-wrap (a−b), 2 unsigned saturating add, 3 unsigned max. Latched at launch.
- length  in  HOST_DATA_BITS  vector length in beats. Latched at launch.
- a_addr, b_addr, c_addr  in  HOST_DATA_BITS  byte base addresses. Latched at launch.
- finish  out  1  one-cycle completion pulse.
- event_counter_valid  out  1  pulses with finish.
- event_counter_value  out  HOST_DATA_BITS  cycles from launch to finish.
- mem_req_valid  out  1  one-cycle request strobe.
- mem_req_opcode  out  1  0 read, 1 write.
- mem_req_len  out  MEM_LEN_BITS  beats−1.
- mem_req_addr  out  MEM_ADDR_BITS  burst byte address.
- mem_wr_valid  out  1  write beat valid.
- mem_wr_bits  out  MEM_DATA_BITS  write data.
- mem_rd_valid  in  1  read beat valid.
- mem_rd_bits  in  MEM_DATA_BITS  read data.
- mem_rd_ready  out  1  read beat accepted when high together with mem_rd_valid.

## Operation
- States: IDLE → RD_A_REQ → RD_A_DATA → RD_B_REQ → RD_B_DATA → WR_REQ → WR_DATA, then back to RD_A_REQ or on to DONE → IDLE.
- IDLE: on a launch rising edge, latch mode, length and the three addresses. Clear the counter and set rem=length.
  - length=0: go straight to DONE.
- Burst size n = min(rem, MAX_BURST). Fixed at entry to RD_A_REQ.
- RD_A_REQ: one-cycle read request, len=n−1, addr=a_ptr.
  - RD_A_DATA: mem_rd_ready=1; each accepted beat is stored in buf[i]. After n beats → RD_B_REQ.
- RD_B_REQ / RD_B_DATA: same handshake on b_ptr. Each accepted beat is combined lane-wise with buf[i], and the result overwrites buf[i].
- WR_REQ: one-cycle write request, opcode=1, addr=c_ptr.
  - WR_DATA: mem_wr_valid=1 for exactly n consecutive cycles, emitting buf[0..n−1]. There is no backpressure.
- After WR_DATA:
  - Add n·(MEM_DATA_BITS/8) to each pointer, modulo 2^MEM_ADDR_BITS.
  - Set rem −= n.
  - rem>0 → RD_A_REQ; otherwise → DONE.
- DONE: finish=1 and event_counter_valid=1 for one cycle, then IDLE.
- Lane arithmetic works on ELEM_BITS unsigned values.
  - Wrap modes drop the carry/borrow.
  - Saturating add clamps to 2^ELEM_BITS−1.
  - Max is an unsigned compare.
- Launch edges outside IDLE are ignored. The edge detector still tracks the input, so a level held through DONE does not relaunch.
- Counter: increments every cycle from the cycle after launch through DONE inclusive. It saturates at all-ones and holds its value in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, buffer contents don't-care. Reset mid-transfer aborts immediately with no finish pulse.
- mem_req_valid is high exactly one cycle per burst. The first data cycle follows it on the next cycle.
- Read beats may arrive with gaps; only valid&&ready beats count.
- Beats arriving outside the *_DATA states are not accepted (mem_rd_ready=0).
- Result beat i is written k cycles after WR_REQ, with k=i+1.
- Minimum latency for length L, assuming zero-gap reads and memory returning data the cycle after the request: sum over bursts of (3 + 3n) cycles, plus 1 for DONE.
- mem_wr_bits is registered and comes straight from the buffer. There is no combinational path from mem_rd_* to mem_wr_*.

## Structure
- Package vec_alu_pkg holds:
  - the alu_mode_t enum (ADD, SUB, SADD, MAX);
  - the state_t enum;
  - the LANES derivation function.
- Sub-module vec_alu_lane: combinational, one ELEM_BITS lane. Inputs a, b, mode; output y. Generate it LANES times.
- Buffer: MAX_BURST × MEM_DATA_BITS register array with one read/write index.

## Test plan
- length=4, mode=ADD, A bytes 0x01..0x20, B all 0x01: C=A+1 per byte; four write beats; finish once; counter=16.
- mode=SADD, A=0xF0 lanes, B=0x20 lanes → C=0xFF in every lane. mode=SUB, A=0x00, B=0x01 → 0xFF (wrap).
- length=37, MAX_BURST=16, mode=MAX: bursts of 16,16,5; req_len 15,15,4; addresses step 128 bytes; C matches the reference model.
- Random mem_rd_valid gaps (30% idle) with length=20: results unchanged; writes remain contiguous per burst.
- length=0 → finish the cycle after DONE entry, no memory requests. Launch held high across finish → no restart.
- Assert reset during RD_B_DATA → all outputs 0 the same cycle, no finish. A subsequent launch completes correctly.
